// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - signed multiply-accumulate dot-product sequencer
//
// Purpose: computes result = bias + sum(value*mult) over len operand pairs.
// The product is the full 2*N-bit signed product, and the sum wraps modulo
// 2**(2*N). A length of zero presents the bias directly.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_ni       synchronous active-low reset
//   start_i      start a new dot product (honoured only in IDLE)
//   len_i        number of operand pairs, sampled with start_i
//   bias_i       signed accumulator initial value, sampled with start_i
//   busy_o       high in every state except IDLE
//   in_valid_i   operand pair valid
//   in_ready_o   operand pair accepted this cycle (ACCUM only)
//   value_i      signed activation operand
//   mult_i       signed weight operand
//   out_valid_o  result_o holds a completed dot product
//   out_ready_i  downstream accepts result_o
//   result_o     signed result; reads 0 while out_valid_o is low
module mac_sequencer #(
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [2*N-1:0]   bias_i,
  output logic             busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     value_i,
  input  logic [N-1:0]     mult_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2*N-1:0]   result_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q;
  logic [2*N-1:0]   acc_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  logic             beat;
  logic [LEN_W-1:0] cnt_next;
  logic [2*N-1:0]   value_ext;
  logic [2*N-1:0]   mult_ext;
  logic [2*N-1:0]   prod;

  // Sign-extending both operands to 2*N bits before multiplying gives
  // the exact signed product in the low 2*N bits of the result.
  assign value_ext = {{N{value_i[N-1]}}, value_i};
  assign mult_ext  = {{N{mult_i[N-1]}}, mult_i};
  assign prod      = value_ext * mult_ext;

  assign beat     = in_valid_i && in_ready_o;
  // The counter tops out at len_q, so it never needs to wrap, even when
  // the length is 2**LEN_W-1.
  assign cnt_next = cnt_q + 1'b1;

  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = (state_q == S_ACCUM);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = out_valid_o ? acc_q : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            acc_q <= bias_i;
            cnt_q <= '0;
            len_q <= len_i;
            state_q <= (len_i == '0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc_q <= acc_q + prod;
            cnt_q <= cnt_next;
            if (cnt_next == len_q) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - self-checking bench for mac_sequencer
module tb_mac_sequencer;
  localparam int N     = 8;
  localparam int LEN_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic [2*N-1:0]   bias_i = '0;
  logic             busy_o;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [N-1:0]     value_i = '0;
  logic [N-1:0]     mult_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [2*N-1:0]   result_o;

  int checks = 0;
  int errors = 0;
  int vq[$];
  int mq[$];

  mac_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i),
    .bias_i(bias_i), .busy_o(busy_o), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .value_i(value_i), .mult_i(mult_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: bias plus the plain integer dot product, reduced mod 2**16.
  function automatic logic [15:0] ref_dot(input logic [15:0] bias);
    longint s;
    s = longint'($signed(bias));
    foreach (vq[i]) s += longint'(vq[i]) * longint'(mq[i]);
    return s[15:0];
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_random(input int len);
    vq.delete();
    mq.delete();
    for (int i = 0; i < len; i++) begin
      vq.push_back($urandom_range(255) - 128);
      mq.push_back($urandom_range(255) - 128);
    end
  endtask

  task automatic drive_pair(input int idx);
    int tv;
    int tm;
    tv = vq[idx];
    tm = mq[idx];
    value_i = tv[7:0];
    mult_i  = tm[7:0];
  endtask

  // Runs one complete operation using vq/mq as the operand pairs.
  task automatic do_op(input string name, input int len, input logic [15:0] bias,
                       input int gap_pct, input int hold, input bit poke);
    logic [15:0] exp;
    int beats;
    int lv;
    exp = ref_dot(bias);
    lv = len;
    start_i = 1'b1;
    len_i = lv[7:0];
    bias_i = bias;
    step();
    start_i = 1'b0;
    beats = 0;
    while (beats < len) begin
      checks++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b1 || result_o !== 16'h0) begin
        errors++;
        $display("FAIL %s accum_state: ready=%b valid=%b busy=%b result=%h, required 1 0 1 0000",
                 name, in_ready_o, out_valid_o, busy_o, result_o);
      end
      in_valid_i = ($urandom_range(99) >= gap_pct);
      drive_pair(beats);
      if (poke && $urandom_range(2) == 0) begin
        start_i = 1'b1;
        len_i = LEN_W'($urandom);
        bias_i = 16'($urandom);
      end
      step();
      start_i = 1'b0;
      if (in_valid_i) beats++;
    end
    in_valid_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== exp || in_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s done_latency: valid=%b result=%h ready=%b busy=%b, required 1 %h 0 1",
               name, out_valid_o, result_o, in_ready_o, busy_o, exp);
    end
    for (int h = 0; h < hold; h++) begin
      out_ready_i = 1'b0;
      start_i = poke;
      step();
      start_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== exp || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL %s hold_%0d: valid=%b result=%h ready=%b, required 1 %h 0",
                 name, h, out_valid_o, result_o, in_ready_o, exp);
      end
    end
    out_ready_i = 1'b1;
    start_i = poke;
    len_i = 8'd1;
    step();
    out_ready_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== 16'h0 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: busy=%b valid=%b result=%h ready=%b, required 0 0 0000 0",
               name, busy_o, out_valid_o, result_o, in_ready_o);
    end
    if (poke) begin
      step();
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL %s handshake_start_ignored: busy=%b, required 0", name, busy_o);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    step();
    step();
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ready=%b valid=%b result=%h, required 0 0 0 0000",
               busy_o, in_ready_o, out_valid_o, result_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    vq = '{2, -4, 7};
    mq = '{3, 5, -1};
    do_op("basic", 3, 16'd10, 0, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    vq.delete();
    mq.delete();
    do_op("zero_len", 0, 16'hFFFB, 0, 2, 1'b0);
  endtask

  task automatic test_gaps_backpressure();
    fill_random(4);
    do_op("gaps_bp", 4, 16'($urandom), 50, 5, 1'b0);
  endtask

  task automatic test_wrap();
    vq = '{127};
    mq = '{127};
    do_op("wrap", 1, 16'h7FFF, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    fill_random(4);
    start_i = 1'b1;
    len_i = 8'd4;
    bias_i = 16'h1234;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      drive_pair(i);
      step();
    end
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    step();
    checks++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b ready=%b valid=%b result=%h, required 0 0 0 0000",
               busy_o, in_ready_o, out_valid_o, result_o);
    end
    rst_ni = 1'b1;
    vq = '{3};
    mq = '{3};
    do_op("after_abort", 1, 16'd0, 0, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_random(5);
    do_op("start_ignored", 5, 16'($urandom), 30, 2, 1'b1);
  endtask

  task automatic test_max_len();
    fill_random(255);
    do_op("max_len", 255, 16'($urandom), 10, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int len;
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(10);
      fill_random(len);
      do_op("random", len, 16'($urandom), 30, $urandom_range(3), 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps_backpressure();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_max_len();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
